button_conditioner: RTL
=======================

# button_conditioner

Input front end for the goose game: takes the raw, asynchronous, bouncing push-button pins (ui_in[1:0]) and produces clean, synchronized, active-high levels plus single-cycle press/release/long-hold pulses. Sits between the top-level ui_in pins and the game logic. jump_button feeds jumping.jump and reset_button feeds game_controller.reset_button, replacing the bare inversion in the top level. One independent debounce channel per button.

## Interface
- NUM_BUTTONS, 2, number of independent channels
- DEBOUNCE_CYCLES, 250000, cycles input must be stable before a level change is accepted (10 ms @ 25 MHz); legal range ≥ 2
- HOLD_CYCLES, 25000000, cycles after acceptance of a press before btn_long fires (1 s @ 25 MHz); legal range ≥ 1
- ACTIVE_LOW, 1, 1 = raw pin reads 0 when pressed

Ports:
- clk  input  1  system clock (pixel clock)
- sys_rst  input  1  synchronous, active-high reset
- btn_raw  input  NUM_BUTTONS  raw pin levels, asynchronous to clk
- btn_level  output  NUM_BUTTONS  debounced pressed state, active-high
- btn_press  output  NUM_BUTTONS  one-cycle pulse on accepted press
- btn_release  output  NUM_BUTTONS  one-cycle pulse on accepted release
- btn_long  output  NUM_BUTTONS  one-cycle pulse, once per press, after HOLD_CYCLES of continuous acceptance

## Operation
- Per channel: 2-flop synchronizer, then polarity normalisation (invert if ACTIVE_LOW) giving sample s (1 = pressed).
- Synchronizer flops reset to the idle pin level (1 if ACTIVE_LOW, else 0).
- Channel FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state IDLE.
- IDLE: s=1 → PRESS_WAIT, clear debounce counter.
- PRESS_WAIT: s=0 → IDLE, no pulse. Otherwise count. On reaching DEBOUNCE_CYCLES consecutive s=1 samples → PRESSED.
  - Entry to PRESSED: btn_press=1 for one cycle, btn_level=1, hold counter cleared.
- PRESSED: s=0 → RELEASE_WAIT, clear debounce counter.
  - Hold counter increments every cycle in PRESSED and RELEASE_WAIT.
  - Hold counter saturates at HOLD_CYCLES.
  - btn_long pulses on the cycle the counter first reaches HOLD_CYCLES; never again until the next press.
- RELEASE_WAIT: s=1 → PRESSED with no pulse, and the hold counter is not cleared (bounce is transparent). After DEBOUNCE_CYCLES consecutive s=0 samples → IDLE.
  - Entry to IDLE from RELEASE_WAIT: btn_release=1 for one cycle, btn_level=0.
- btn_level=1 exactly in PRESSED and RELEASE_WAIT.
- Any input pulse/glitch shorter than DEBOUNCE_CYCLES samples produces no output change.
- Channels are fully independent. Simultaneous presses on all channels produce simultaneous pulses.
- Button already held at reset release: treated as a fresh press, so btn_press fires after normal latency.
- btn_long and btn_release may never coincide with btn_press on the same channel. btn_long may coincide with the RELEASE_WAIT → IDLE transition only if HOLD_CYCLES is reached that cycle; both pulses are then issued.
- Counter widths: $clog2(DEBOUNCE_CYCLES+1) and $clog2(HOLD_CYCLES+1), unsigned. No wrap is possible: debounce counters clear on state change, and the hold counter saturates.

## Timing
- sys_rst sampled on clk rising edge. While asserted, all outputs are 0, FSMs are in IDLE, and counters are 0.
- Reset asserted mid-debounce or mid-press: outputs drop to 0 on the next edge, with no release pulse.
- Latency: btn_raw settles to pressed level before edge 0. btn_press and btn_level rise after edge DEBOUNCE_CYCLES+2, and btn_press is high for exactly one cycle. Release latency is identical.
- btn_long rises HOLD_CYCLES cycles after btn_press rises.
- All outputs are registered. There are no combinational paths from btn_raw.

## Structure
- State encodings (2-bit localparams) and default DEBOUNCE_CYCLES/HOLD_CYCLES constants go in the shared game constants include, so jumping/scroll timing can reference the same clock rate.
- Sub-module debounce_channel: one synchronizer, FSM, and counter set, with scalar ports. button_conditioner instantiates NUM_BUTTONS copies via generate and concatenates the outputs.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, ACTIVE_LOW=1.
- Clean press: btn_raw[0] 1→0 before edge 0, held → btn_press[0] high only after edge 6, btn_level[0]=1 thereafter. Channel 1 is silent.
- Bounce: btn_raw[0] toggles with 0-runs of 1, 2 and 3 cycles, then held low → exactly one btn_press, 4+2 edges after the last falling edge.
- Release with bounce: from PRESSED, raw high for 2 cycles, low for 1, then high → btn_level stays 1 through the bounce. One btn_release, 6 edges after the final rise, and no second btn_press.
- Long hold: hold pressed 30 cycles after btn_press → exactly one btn_long, 16 cycles after btn_press. A 1-cycle release glitch at cycle 10 does not delay it.
- Reset mid-press: assert sys_rst for 1 cycle while PRESSED → all outputs 0 next cycle, no btn_release. With the button still held, a new btn_press arrives 6 edges after reset deassertion.
- Simultaneous: both raw pins go low on the same cycle → btn_press=2'b11 on one cycle.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared game timing constants and the button-channel state encoding.
// Defaults assume the 25 MHz pixel clock.
package button_conditioner_pkg;

    localparam int unsigned CLK_HZ                  = 25_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250_000;     // 10 ms
    localparam int unsigned DEFAULT_HOLD_CYCLES     = 25_000_000;  // 1 s

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] ST_PRESSED      = 2'd2;
    localparam logic [1:0] ST_RELEASE_WAIT = 2'd3;

    typedef enum logic [1:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        PRESSED      = ST_PRESSED,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } btn_state_e;

    // Per-channel registered output set.
    typedef struct packed {
        logic level;
        logic press;
        logic rel;
        logic lng;
    } btn_event_t;

endpackage

// File: rtl/button_conditioner_channel.sv
// One button: 2-flop synchronizer, debounce FSM, and hold timer.
// Produces a clean level plus press/release/long-hold pulses.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic sys_rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic              IDLE_PIN  = ACTIVE_LOW;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    logic [1:0]        sync_q;
    logic              sample;
    btn_state_e        state_q, state_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    btn_event_t        evt_q, evt_d;

    // Synchronizer idles at the released pin level so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            sync_q <= {2{IDLE_PIN}};
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign sample = sync_q[1] ^ IDLE_PIN;

    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q    <= IDLE;
            db_cnt_q   <= '0;
            hold_cnt_q <= '0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            db_cnt_q   <= db_cnt_d;
            hold_cnt_q <= hold_cnt_d;
            evt_q      <= evt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        db_cnt_d   = db_cnt_q;
        hold_cnt_d = hold_cnt_q;
        evt_d      = '0;

        unique case (state_q)
            IDLE: begin
                if (sample) begin
                    state_d  = PRESS_WAIT;
                    db_cnt_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sample) begin
                    state_d = IDLE;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d     = PRESSED;
                    hold_cnt_d  = '0;
                    evt_d.press = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            PRESSED: begin
                if (!sample) begin
                    state_d  = RELEASE_WAIT;
                    db_cnt_d = '0;
                end
            end
            RELEASE_WAIT: begin
                // A return to pressed is a bounce: keep the hold timer running.
                if (sample) begin
                    state_d = PRESSED;
                end else if (db_cnt_q == DB_LAST) begin
                    state_d   = IDLE;
                    evt_d.rel = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DB_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Saturating hold timer; the pulse fires only on the step into saturation.
        if (state_q == PRESSED || state_q == RELEASE_WAIT) begin
            if (hold_cnt_q != HOLD_MAX) begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end
            evt_d.lng = (hold_cnt_q == HOLD_LAST);
        end

        evt_d.level = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    assign btn_level   = evt_q.level;
    assign btn_press   = evt_q.press;
    assign btn_release = evt_q.rel;
    assign btn_long    = evt_q.lng;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: one independent debounce channel per raw pin.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int unsigned NUM_BUTTONS     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned HOLD_CYCLES     = DEFAULT_HOLD_CYCLES,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic [NUM_BUTTONS-1:0] btn_raw,
    output logic [NUM_BUTTONS-1:0] btn_level,
    output logic [NUM_BUTTONS-1:0] btn_press,
    output logic [NUM_BUTTONS-1:0] btn_release,
    output logic [NUM_BUTTONS-1:0] btn_long
);

    for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_chan
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .HOLD_CYCLES     (HOLD_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_chan (
            .clk         (clk),
            .sys_rst     (sys_rst),
            .btn_raw     (btn_raw[gi]),
            .btn_level   (btn_level[gi]),
            .btn_press   (btn_press[gi]),
            .btn_release (btn_release[gi]),
            .btn_long    (btn_long[gi])
        );
    end

endmodule
